// File: rtl/bit_serializer_pkg.sv
// ============================================================================
// Module  : bit_serializer_pkg
// Brief   : Shared state encoding and counter-width helpers for bit_serializer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bit_serializer_pkg;

    typedef logic [0:0] state_t;

    localparam state_t c_ST_IDLE  = 1'b0;
    localparam state_t c_ST_SHIFT = 1'b1;

    localparam int c_DEFAULT_WIDTH = 8;
    localparam int c_DEFAULT_CNT_W = $clog2(c_DEFAULT_WIDTH);

    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bit_serializer.sv
// ============================================================================
// Module  : bit_serializer
// Brief   : Parallel-to-serial converter with one-word pending buffer and
//           gapless back-to-back output; drives an idle level when empty.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter bit   LSB_FIRST  = 1'b0,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             serial_out,
    output logic             bit_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int                 c_CNT_W = cnt_width(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_shift;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic [WIDTH-1:0]   r_pend_data;
    logic               r_pend_valid;

    logic w_shifting;
    logic w_free;
    logic w_accept;
    logic w_head_bit;

    assign w_shifting = (r_state == c_ST_SHIFT);
    // The shifter can take a new word at this edge once its last bit is out.
    assign w_free     = !w_shifting || (r_bit_cnt == c_LAST);
    assign ready_out  = !r_pend_valid && !reset;
    assign w_accept   = valid_in && ready_out;
    assign w_head_bit = LSB_FIRST ? r_shift[0] : r_shift[WIDTH-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_pend_data  <= '0;
            r_pend_valid <= 1'b0;
        end else if (w_free) begin
            if (r_pend_valid) begin
                r_shift      <= r_pend_data;
                r_bit_cnt    <= '0;
                r_state      <= c_ST_SHIFT;
                r_pend_valid <= w_accept;
                if (w_accept) begin
                    r_pend_data <= data_in;
                end
            end else if (w_accept) begin
                r_shift   <= data_in;
                r_bit_cnt <= '0;
                r_state   <= c_ST_SHIFT;
            end else begin
                r_state <= c_ST_IDLE;
            end
        end else begin
            // Mid-word: the shifter keeps advancing while a new word may park in pending.
            if (w_accept) begin
                r_pend_data  <= data_in;
                r_pend_valid <= 1'b1;
            end
            r_shift   <= LSB_FIRST ? (r_shift >> 1) : (r_shift << 1);
            r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end

    always_comb begin
        serial_out  = IDLE_LEVEL;
        bit_valid   = 1'b0;
        frame_start = 1'b0;
        busy        = 1'b0;
        if (!reset) begin
            serial_out  = w_shifting ? w_head_bit : IDLE_LEVEL;
            bit_valid   = w_shifting;
            frame_start = w_shifting && (r_bit_cnt == '0);
            busy        = w_shifting || r_pend_valid;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bit_serializer.sv
// ============================================================================
// Module  : tb_bit_serializer
// Brief   : Self-checking bench: directed table, hand sequences and random
//           traffic against a bit-queue reference model (MSB and LSB variants).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bit_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         vld;
    logic [W-1:0] din;

    logic rdy0, ser0, bv0, fs0, bsy0;
    logic rdy1, ser1, bv1, fs1, bsy1;

    int errors = 0;
    int checks = 0;

    // Expected outgoing bits as {first_of_word, bit}; the head is what should show now.
    logic [1:0] q0[$];
    logic [1:0] q1[$];

    typedef struct {
        logic       rst;
        logic       vld;
        logic [7:0] din;
        logic       ser;
        logic       bv;
        logic       fs;
        logic       rdy;
        logic       bsy;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(W), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut0 (
        .clock(clk), .reset(rst), .data_in(din), .valid_in(vld),
        .ready_out(rdy0), .serial_out(ser0), .bit_valid(bv0),
        .frame_start(fs0), .busy(bsy0)
    );

    bit_serializer #(.WIDTH(W), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut1 (
        .clock(clk), .reset(rst), .data_in(din), .valid_in(vld),
        .ready_out(rdy1), .serial_out(ser1), .bit_valid(bv1),
        .frame_start(fs1), .busy(bsy1)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {serial, bit_valid, frame_start, ready, busy} from the bit queue.
    function automatic logic [4:0] model_out(input bit lsb);
        logic [1:0] h;
        int         sz;
        logic       idle;
        idle = lsb;
        sz   = lsb ? q1.size() : q0.size();
        if (rst)     return {idle, 4'b0000};
        if (sz == 0) return {idle, 4'b0010};
        h = lsb ? q1[0] : q0[0];
        return {h[0], 1'b1, h[1], (sz <= W), 1'b1};
    endfunction

    task automatic model_check();
        chk("msb dut outputs", {3'b0, ser0, bv0, fs0, rdy0, bsy0}, {3'b0, model_out(1'b0)});
        chk("lsb dut outputs", {3'b0, ser1, bv1, fs1, rdy1, bsy1}, {3'b0, model_out(1'b1)});
    endtask

    task automatic edge_update();
        bit acc;
        acc = vld && !rst && (q0.size() <= W);
        @(posedge clk);
        if (rst) begin
            q0.delete();
            q1.delete();
        end else begin
            if (q0.size() > 0) void'(q0.pop_front());
            if (q1.size() > 0) void'(q1.pop_front());
            if (acc) begin
                for (int i = W - 1; i >= 0; i--) q0.push_back({1'(i == W - 1), din[i]});
                for (int i = 0; i < W; i++)      q1.push_back({1'(i == 0), din[i]});
            end
        end
        #1;
    endtask

    task automatic cyc();
        @(negedge clk);
        model_check();
        edge_update();
    endtask

    task automatic drive(input logic r, input logic v, input logic [7:0] d);
        rst = r;
        vld = v;
        din = d;
    endtask

    initial begin
        logic [7:0] bits;
        logic [3:0] win;
        logic [7:0] hits;

        // Single word 1001_0000, MSB first, then idle.
        tbl.push_back('{0, 1, 8'h90, 0, 0, 0, 1, 0});
        tbl.push_back('{0, 0, 8'h00, 1, 1, 1, 1, 1});
        tbl.push_back('{0, 0, 8'h00, 0, 1, 0, 1, 1});
        tbl.push_back('{0, 0, 8'h00, 0, 1, 0, 1, 1});
        tbl.push_back('{0, 0, 8'h00, 1, 1, 0, 1, 1});
        tbl.push_back('{0, 0, 8'h00, 0, 1, 0, 1, 1});
        tbl.push_back('{0, 0, 8'h00, 0, 1, 0, 1, 1});
        tbl.push_back('{0, 0, 8'h00, 0, 1, 0, 1, 1});
        tbl.push_back('{0, 0, 8'h00, 0, 1, 0, 1, 1});
        tbl.push_back('{0, 0, 8'h00, 0, 0, 0, 1, 0});
        tbl.push_back('{0, 0, 8'h00, 0, 0, 0, 1, 0});
        // Back-to-back A5 then 3C: gapless, ready low while 3C waits in pending.
        tbl.push_back('{0, 1, 8'hA5, 0, 0, 0, 1, 0});
        tbl.push_back('{0, 1, 8'h3C, 1, 1, 1, 1, 1});
        tbl.push_back('{0, 0, 8'h00, 0, 1, 0, 0, 1});
        tbl.push_back('{0, 0, 8'h00, 1, 1, 0, 0, 1});
        tbl.push_back('{0, 0, 8'h00, 0, 1, 0, 0, 1});
        tbl.push_back('{0, 0, 8'h00, 0, 1, 0, 0, 1});
        tbl.push_back('{0, 0, 8'h00, 1, 1, 0, 0, 1});
        tbl.push_back('{0, 0, 8'h00, 0, 1, 0, 0, 1});
        tbl.push_back('{0, 0, 8'h00, 1, 1, 0, 0, 1});
        tbl.push_back('{0, 0, 8'h00, 0, 1, 1, 1, 1});
        tbl.push_back('{0, 0, 8'h00, 0, 1, 0, 1, 1});
        tbl.push_back('{0, 0, 8'h00, 1, 1, 0, 1, 1});
        tbl.push_back('{0, 0, 8'h00, 1, 1, 0, 1, 1});
        tbl.push_back('{0, 0, 8'h00, 1, 1, 0, 1, 1});
        tbl.push_back('{0, 0, 8'h00, 1, 1, 0, 1, 1});
        tbl.push_back('{0, 0, 8'h00, 0, 1, 0, 1, 1});
        tbl.push_back('{0, 0, 8'h00, 0, 1, 0, 1, 1});
        tbl.push_back('{0, 0, 8'h00, 0, 0, 0, 1, 0});

        drive(1, 0, 8'h00);
        repeat (3) cyc();
        drive(0, 0, 8'h00);
        cyc();

        foreach (tbl[k]) begin
            drive(tbl[k].rst, tbl[k].vld, tbl[k].din);
            @(negedge clk);
            model_check();
            chk($sformatf("table row %0d", k), {3'b0, ser0, bv0, fs0, rdy0, bsy0},
                {3'b0, tbl[k].ser, tbl[k].bv, tbl[k].fs, tbl[k].rdy, tbl[k].bsy});
            edge_update();
        end

        // LSB first with idle level 1: word 01 gives 1 then seven 0s, then idle 1.
        drive(0, 1, 8'h01);
        cyc();
        drive(0, 0, 8'h00);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            model_check();
            if (c == 1)      chk("lsb first bit", {6'b0, ser1, fs1}, 8'b11);
            else if (c <= 8) chk($sformatf("lsb bit %0d", c), {7'b0, ser1}, 8'b0);
            else             chk("lsb idle level", {6'b0, ser1, bv1}, 8'b10);
            edge_update();
        end

        // Reset during bit 4 with a second word pending.
        drive(0, 1, 8'hC3); cyc();
        drive(0, 1, 8'h5A); cyc();
        drive(0, 0, 8'h00); cyc(); cyc();
        drive(1, 0, 8'h00);
        @(negedge clk);
        model_check();
        chk("in-reset ready/bv/busy", {5'b0, rdy0, bv0, bsy0}, 8'b000);
        edge_update();
        drive(0, 1, 8'hE7);
        @(negedge clk);
        model_check();
        chk("post-reset idle", {4'b0, bv0, bsy0, rdy0, ser0}, 8'b0010);
        edge_update();
        drive(0, 0, 8'h00);
        @(negedge clk);
        model_check();
        chk("post-reset frame_start", {6'b0, fs0, ser0}, 8'b11);
        edge_update();
        repeat (7) cyc();
        @(negedge clk);
        model_check();
        chk("no residual bits", {6'b0, bv0, bsy0}, 8'b00);
        edge_update();

        // 1001_1001 MSB first: a 1001 detector matches at serial bits 4 and 8.
        drive(0, 1, 8'b1001_1001);
        cyc();
        drive(0, 0, 8'h00);
        bits = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            model_check();
            bits[c] = ser0 & bv0;
            edge_update();
        end
        win  = '0;
        hits = '0;
        for (int i = 0; i < 8; i++) begin
            win = {win[2:0], bits[i]};
            if (i >= 3 && win == 4'b1001) hits[i] = 1'b1;
        end
        chk("1001 match positions", hits, 8'b1000_1000);

        // Random traffic with heavy valid and occasional reset.
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) != 0), 8'($urandom));
            cyc();
        end
        drive(0, 0, 8'h00);
        repeat (20) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
